// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: shows one packed-BCD digit at a time through a shared decoder.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  common_anode,
    output logic [3:0]            bcd,
    output logic                  blank,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int CNT_MAX = (PRESCALE > DEAD_CYC) ? PRESCALE : DEAD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(DIGITS);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pvld_q, pvld_d;
    logic [3:0]            bcd_q, bcd_d;
    logic                  blank_q, blank_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic                  fd_q, fd_d;

    logic [3:0]            cur_digit;
    logic                  lz_blank;

    // Digit at idx_q, plus whether it is a leading zero (idx>0, it and all higher digits zero).
    always_comb begin
        logic run;
        cur_digit = 4'h0;
        lz_blank  = 1'b0;
        run       = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) cur_digit = disp_q[4*k +: 4];
        end
        for (int k = DIGITS - 1; k > 0; k--) begin
            run = run & (disp_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) lz_blank = run;
        end
`ifndef SEG_SCAN_LZB_EN
        lz_blank = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        pvld_d  = pvld_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        sel_d   = sel_q;
        fd_d    = 1'b0;

        if (!enable) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            blank_d = 1'b1;
            sel_d   = '0;
        end else begin
            case (state_q)
                ST_DEAD: begin
                    if (cnt_q == CNT_W'(DEAD_CYC - 1)) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        bcd_d   = cur_digit;
                        blank_d = lz_blank;
                        sel_d   = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_W'(PRESCALE - 1)) begin
                        state_d = ST_DEAD;
                        cnt_d   = '0;
                        blank_d = 1'b1;
                        sel_d   = '0;
                        if (idx_q == IDX_W'(DIGITS - 1)) begin
                            // Frame boundary: the only point where the displayed value may change.
                            idx_d = '0;
                            fd_d  = 1'b1;
                            if (pvld_q) begin
                                disp_d = pend_q;
                                pvld_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_DEAD;
            endcase
        end

        // A load in the commit cycle overrides the clear so it lands in the next frame.
        if (load) begin
            pend_d = value;
            pvld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DEAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            pvld_q  <= 1'b0;
            bcd_q   <= 4'h0;
            blank_q <= 1'b1;
            sel_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
        end
    end

    assign bcd        = bcd_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;
    assign digit_sel  = sel_q ^ {DIGITS{common_anode}};

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display sharing a single `bcd2seg` decoder. It holds a packed BCD value and presents one digit at a time on the decoder's `bcd`/`blank` inputs, while driving the matching digit-select line. It inserts a dead interval between digits for ghost suppression and commits new values only at frame boundaries, so a displayed number never tears. It sits between the counter/datapath logic producing BCD values and the `bcd2seg` decoder feeding the segment pins.

## Interface
- `DIGITS`, 4: number of digits scanned; index 0 is least significant; minimum 2.
- `PRESCALE`, 50000: cycles each digit is shown (SHOW phase); minimum 1.
- `DEAD_CYC`, 500: cycles all digits are off between digits (DEAD phase); minimum 1.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `value`  in  4*DIGITS  packed BCD; digit k at bits [4k+3:4k].
- `load`  in  1  one-cycle strobe; captures `value` into the pending register.
- `enable`  in  1  scanning enable; low forces display dark.
- `common_anode`  in  1  digit-select polarity; same meaning as on `bcd2seg`.
- `bcd`  out  4  current digit to decoder.
- `blank`  out  1  decoder blank; 1 = all segments off.
- `digit_sel`  out  DIGITS  one-hot digit select; active-high when `common_anode`=0, active-low (bitwise inverted) when 1.
- `frame_done`  out  1  one-cycle pulse when a full scan frame completes.

## Operation
- Registers: `disp` (displayed value), `pending`, `pending_vld`, `idx` (0..DIGITS-1), phase counter, state.
- States: DEAD, SHOW.
- DEAD: `blank`=1, `sel_raw`=0, held for DEAD_CYC cycles, then SHOW.
- SHOW: `bcd`=`disp` digit `idx`; `sel_raw` one-hot bit `idx`; held PRESCALE cycles, then DEAD with `idx` incremented.
- `idx` wrap DIGITS-1 -> 0 at SHOW->DEAD: `frame_done` pulses; if `pending_vld`, `disp`<=`pending`, `pending_vld`<=0.
- `load`: `pending`<=`value`, `pending_vld`<=1; multiple loads per frame keep the last value.
- `load` in the commit cycle: the commit uses the old `pending`; the new value is captured with `pending_vld`=1 and is applied at the next frame.
- `enable`=0: state forced to DEAD, counter cleared, `idx` held; `load` is still accepted. `enable` rising: DEAD_CYC dead cycles, then SHOW at the held `idx`.
- Non-BCD nibbles (10-15) pass through unmodified; the decoder renders them blank.
- `digit_sel` = `sel_raw` XOR {DIGITS{`common_anode`}} (combinational on the registered one-hot).

## Timing
- Reset values: state DEAD, counter 0, `idx`=0, `disp`=0, `pending`=0, `pending_vld`=0, `bcd`=0, `blank`=1, `sel_raw`=0, `frame_done`=0.
- `bcd`, `blank`, `sel_raw`, and `frame_done` are registered; they change on the clock edge that enters the state.
- After reset release with `enable`=1: DEAD_CYC cycles dark, then digit 0 shown.
- Frame length: DIGITS*(PRESCALE+DEAD_CYC) cycles.
- `frame_done` is high during the first DEAD cycle after digit DIGITS-1.
- `load` -> visible: at most one frame plus DEAD_CYC cycles.
- Reset mid-frame: returns to reset values immediately; `pending` is discarded.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking. In SHOW, `blank`=1 for digit `idx`>0 when that digit and all higher digits of `disp` are 0. Digit 0 is never blanked. `digit_sel` still strobes normally.
- `SEG_SCAN_LZB_EN` not defined: `blank`=1 only in DEAD or when disabled.

## Test plan
- Bench parameters: DIGITS=4, PRESCALE=4, DEAD_CYC=1 (frame = 20 cycles).
- Reset release, `enable`=1, `common_anode`=0 -> 1 cycle dark; then `digit_sel`=0001, `bcd`=0 for 4 cycles; dead cycle; `digit_sel`=0010; and so on. `frame_done` pulses at cycle 20.
- `load` `value`=16'h1234 mid-frame -> current frame shows 0000; next frame shows digits 4,3,2,1 on `digit_sel` 0001,0010,0100,1000.
- `load` 16'h5678, then 16'h9999 in the same frame; also `load` in the `frame_done` commit cycle -> only the last pre-commit value is displayed; the commit-cycle value appears one frame later.
- `common_anode`=1 -> `digit_sel` = 1110/1101/1011/0111 in SHOW and 1111 in DEAD.
- `enable` dropped during digit 2, held 10 cycles, raised -> `blank`=1 and `digit_sel` inactive while low; 1 dead cycle after rising, then digit 2 resumes.
- With `SEG_SCAN_LZB_EN`, `value`=16'h0050 -> digits 3 and 2 are blanked, digits 1 and 0 are shown (5, 0). `value`=0 -> only digit 0 is shown ("0"). Reset asserted mid-SHOW -> `blank`=1 and `sel_raw`=0 immediately.
